// File: rtl/vc_link_sched_pkg.sv
// Shared flit format, sizing constants and scheduler state encoding for the VC link scheduler.
package vc_link_sched_pkg;

  localparam int unsigned NumVirtChn    = 3;
  localparam int unsigned VcWidth       = $clog2(NumVirtChn);
  localparam int unsigned FlitWidth     = 32;
  localparam int unsigned FlitTypeWidth = 2;
  localparam int unsigned PktSizeWidth  = 8;
  localparam int unsigned FlitDataWidth = FlitWidth - FlitTypeWidth - PktSizeWidth;

  typedef enum logic [FlitTypeWidth-1:0] {
    HEAD_FLIT = 2'd0,
    BODY_FLIT = 2'd1,
    TAIL_FLIT = 2'd2
  } flit_type_t;

  // pkt_size counts the flits that follow the head; 0 means a single-flit packet
  typedef struct packed {
    flit_type_t                flit_type;
    logic [PktSizeWidth-1:0]   pkt_size;
    logic [FlitDataWidth-1:0]  data;
  } s_flit_head_data_t;

  typedef enum logic {SCHED_UNLOCKED, SCHED_LOCKED} sched_st_t;

endpackage

// File: rtl/vc_link_sched_rr_arb.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping at NumVc-1.
module vc_rr_arb #(
  parameter int unsigned NumVc   = 3,
  parameter int unsigned VcWidth = $clog2(NumVc)
) (
  input  logic [NumVc-1:0]   req,
  input  logic [VcWidth-1:0] ptr,
  input  logic               en,
  output logic [NumVc-1:0]   gnt,
  output logic [VcWidth-1:0] gnt_idx
);

  int unsigned idx;
  logic        found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NumVc; i++) begin
      idx = (32'(ptr) + i) % NumVc;
      if (en && !found && req[VcWidth'(idx)]) begin
        found                = 1'b1;
        gnt[VcWidth'(idx)]   = 1'b1;
        gnt_idx              = VcWidth'(idx);
      end
    end
  end

endmodule

// File: rtl/vc_link_sched.sv
// Output-link scheduler: round-robin over VC buffers with wormhole lock and one output register.
module vc_link_sched
  import vc_link_sched_pkg::*;
#(
  parameter int unsigned NumVc     = NumVirtChn,
  parameter int unsigned FlitWidth = vc_link_sched_pkg::FlitWidth,
  parameter int unsigned VcWidth   = $clog2(NumVc)
) (
  input  logic                            clk,
  input  logic                            arst_n,
  input  logic [NumVc-1:0][FlitWidth-1:0] fdata_i,
  input  logic [NumVc-1:0]                valid_i,
  output logic [NumVc-1:0]                ready_o,
  output logic [FlitWidth-1:0]            fdata_o,
  output logic [VcWidth-1:0]              vc_id_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic                            lock_o,
  output logic                            proto_err_o
);

  sched_st_t          state_q, state_d;
  logic [VcWidth-1:0] lock_vc_q, lock_vc_d;
  logic [VcWidth-1:0] rr_ptr_q, rr_ptr_d;
  logic [VcWidth-1:0] gnt_idx;
  logic [NumVc-1:0]   req, gnt, lock_mask;
  logic               can_load, xfer, perr_d;
  logic [FlitWidth-1:0] gnt_flit;
  s_flit_head_data_t  gnt_hdr;

  assign can_load = ~valid_o | ready_i;

  // While locked only the owning VC may request; everyone else starves until the tail
  always_comb begin
    lock_mask            = '0;
    lock_mask[lock_vc_q] = 1'b1;
    req = (state_q == SCHED_LOCKED) ? (valid_i & lock_mask) : valid_i;
  end

  vc_rr_arb #(
    .NumVc   (NumVc),
    .VcWidth (VcWidth)
  ) u_arb (
    .req     (req),
    .ptr     (rr_ptr_q),
    .en      (can_load & arst_n),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign ready_o  = gnt;
  assign xfer     = |gnt;
  assign gnt_flit = fdata_i[gnt_idx];
  assign gnt_hdr  = s_flit_head_data_t'(gnt_flit);
  assign lock_o   = (state_q == SCHED_LOCKED);

  // Lock FSM and round-robin pointer update, driven by the type of the granted flit
  always_comb begin
    state_d   = state_q;
    lock_vc_d = lock_vc_q;
    rr_ptr_d  = rr_ptr_q;
    perr_d    = 1'b0;
    if (xfer) begin
      case (state_q)
        SCHED_UNLOCKED: begin
          rr_ptr_d = (gnt_idx == VcWidth'(NumVc - 1)) ? '0 : gnt_idx + VcWidth'(1);
          if (gnt_hdr.flit_type == HEAD_FLIT) begin
            if (gnt_hdr.pkt_size != '0) begin
              state_d   = SCHED_LOCKED;
              lock_vc_d = gnt_idx;
            end
          end else begin
            perr_d = 1'b1;
          end
        end
        SCHED_LOCKED: begin
          if (gnt_hdr.flit_type == TAIL_FLIT) state_d = SCHED_UNLOCKED;
        end
        default: state_d = SCHED_UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= SCHED_UNLOCKED;
      lock_vc_q   <= '0;
      rr_ptr_q    <= '0;
      proto_err_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_vc_q   <= lock_vc_d;
      rr_ptr_q    <= rr_ptr_d;
      proto_err_o <= perr_d;
    end
  end

  // Output register: load on transfer in, otherwise drain when the router accepts
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid_o <= 1'b0;
      fdata_o <= '0;
      vc_id_o <= '0;
    end else if (xfer) begin
      valid_o <= 1'b1;
      fdata_o <= gnt_flit;
      vc_id_o <= gnt_idx;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

`ifndef NO_ASSERTIONS
  a_grant_onehot: assert property (@(posedge clk) disable iff (!arst_n) $onehot0(ready_o));
  a_pop_needs_valid: assert property (@(posedge clk) disable iff (!arst_n)
    (ready_o & ~valid_i) == '0);
  a_stall_stable: assert property (@(posedge clk) disable iff (!arst_n)
    (valid_o && !ready_i) |=> ($stable(fdata_o) && $stable(vc_id_o)));
`endif

endmodule
